// File: rtl/cronometro_ctrl_pkg.sv
// Shared definitions for the stopwatch start/stop/lap control stage.
package cronometro_ctrl_pkg;

  // FSM state encodings; the numeric values are visible on state_dbg.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_LAP     = 2'd2,
    ST_PAUSED  = 2'd3
  } state_t;

  // Default debounce window: 100 us at the 50 MHz board clock.
  localparam int unsigned DEB_CYCLES_DEFAULT = 5000;

endpackage

// File: rtl/cronometro_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, debouncer and press-edge detector.
module btn_debounce
  import cronometro_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;

  logic          sync1;
  logic          sync2;
  logic [1:0]    sync_valid;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          level_d;

  // Two-flop synchronizer; sync_valid marks when sync2 holds a post-reset sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync_valid <= '0;
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      sync_valid <= {sync_valid[0], 1'b1};
    end
  end

  // A button held through reset must be seen released before it may press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
    end else if (sync_valid[1] && !sync2) begin
      armed <= 1'b1;
    end
  end

  // Debounce counter: level flips after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered rising-edge detector on the debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d & armed;
    end
  end

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch control: start/stop/lap FSM, lap snapshot and display time mux.
module cronometro_ctrl
  import cronometro_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int unsigned DIGITS     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_start,
  input  logic                  btn_lap,
  input  logic [4*DIGITS-1:0]   time_in,
  output logic                  run_en,
  output logic                  clr,
  output logic                  hold,
  output logic [4*DIGITS-1:0]   time_out,
  output logic [1:0]            state_dbg
);

  logic                press_start;
  logic                press_lap;
  state_t              state_q;
  state_t              state_d;
  logic                run_d;
  logic                hold_d;
  logic                clr_d;
  logic                lap_load;
  logic [4*DIGITS-1:0] lap_reg;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start),
    .level   (),
    .press   (press_start)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_lap),
    .level   (),
    .press   (press_lap)
  );

  // Next state and next registered outputs; start has priority over lap.
  always_comb begin
    state_d  = state_q;
    clr_d    = 1'b0;
    lap_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press_start)    state_d = ST_RUNNING;
        else if (press_lap) clr_d   = 1'b1;
      end
      ST_RUNNING: begin
        if (press_start) begin
          state_d = ST_PAUSED;
        end else if (press_lap) begin
          state_d  = ST_LAP;
          lap_load = 1'b1;
        end
      end
      ST_LAP: begin
        if (press_start)    state_d = ST_PAUSED;
        else if (press_lap) state_d = ST_RUNNING;
      end
      ST_PAUSED: begin
        if (press_start) begin
          state_d = ST_RUNNING;
        end else if (press_lap) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they change with it;
    // clr only accompanies a move to IDLE, so run_en is always 0 with it.
    run_d  = (state_d == ST_RUNNING) || (state_d == ST_LAP);
    hold_d = (state_d == ST_LAP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      run_en  <= 1'b0;
      hold    <= 1'b0;
      clr     <= 1'b0;
    end else begin
      state_q <= state_d;
      run_en  <= run_d;
      hold    <= hold_d;
      clr     <= clr_d;
    end
  end

  // Lap snapshot, captured only on the RUNNING to LAP transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_reg <= '0;
    end else if (lap_load) begin
      lap_reg <= time_in;
    end
  end

  // Display mux: frozen snapshot while holding, live time otherwise.
  always_comb begin
    time_out  = hold ? lap_reg : time_in;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Self-checking bench for cronometro_ctrl (DEB_CYCLES=4, DIGITS=5).
module tb_cronometro_ctrl;
  import cronometro_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        btn_start;
  logic        btn_lap;
  logic [19:0] time_in;
  logic        run_en;
  logic        clr;
  logic        hold;
  logic [19:0] time_out;
  logic [1:0]  state_dbg;

  int n_chk  = 0;
  int n_pass = 0;

  cronometro_ctrl #(.DEB_CYCLES(4), .DIGITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .time_in   (time_in),
    .run_en    (run_en),
    .clr       (clr),
    .hold      (hold),
    .time_out  (time_out),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    bit          l;
    logic [19:0] tin;
    logic [1:0]  st;
    bit          run;
    bit          hld;
    logic [19:0] tout;
    int          clr_n;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  // Hold the selected buttons long enough to debounce, release, and let it settle.
  task automatic do_press(input bit s, input bit l, output int clr_n,
                          output int conflict_n, output int trans_n);
    logic [1:0] prev;
    clr_n = 0; conflict_n = 0; trans_n = 0;
    @(posedge clk); #2;
    btn_start = s;
    btn_lap   = l;
    prev = state_dbg;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (clr) clr_n++;
      if (clr && run_en) conflict_n++;
      if (state_dbg != prev) trans_n++;
      prev = state_dbg;
      if (c == 11) begin
        btn_start = 1'b0;
        btn_lap   = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (6) @(posedge clk);
    #2;
  endtask

  function automatic logic [19:0] rand_bcd();
    logic [19:0] v;
    for (int d = 0; d < 5; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    int cn, cf, tr;
    logic [1:0]  m_st;
    logic [19:0] m_lap;
    logic [19:0] tin;
    int          m_clr;
    bit          s, l;
    bit          m_run, m_hold;

    tbl[0]  = '{1, 0, 20'h00100, ST_RUNNING, 1, 0, 20'h00100, 0};
    tbl[1]  = '{0, 1, 20'h00512, ST_LAP,     1, 1, 20'h00512, 0};
    tbl[2]  = '{0, 0, 20'h00999, ST_LAP,     1, 1, 20'h00512, 0};
    tbl[3]  = '{0, 1, 20'h00999, ST_RUNNING, 1, 0, 20'h00999, 0};
    tbl[4]  = '{1, 0, 20'h01000, ST_PAUSED,  0, 0, 20'h01000, 0};
    tbl[5]  = '{0, 1, 20'h01000, ST_IDLE,    0, 0, 20'h01000, 1};
    tbl[6]  = '{1, 0, 20'h00007, ST_RUNNING, 1, 0, 20'h00007, 0};
    tbl[7]  = '{1, 1, 20'h00250, ST_PAUSED,  0, 0, 20'h00250, 0};
    tbl[8]  = '{1, 0, 20'h00300, ST_RUNNING, 1, 0, 20'h00300, 0};
    tbl[9]  = '{0, 1, 20'h00400, ST_LAP,     1, 1, 20'h00400, 0};
    tbl[10] = '{1, 0, 20'h00450, ST_PAUSED,  0, 0, 20'h00450, 0};
    tbl[11] = '{0, 1, 20'h00500, ST_IDLE,    0, 0, 20'h00500, 1};
    tbl[12] = '{0, 1, 20'h00600, ST_IDLE,    0, 0, 20'h00600, 1};

    rst = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; time_in = 20'h00042;
    #1;
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_run",   32'(run_en), 0);
    chk("rst_clr",   32'(clr), 0);
    chk("rst_hold",  32'(hold), 0);
    chk("rst_tout",  32'(time_out), 32'h00042);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (6) @(posedge clk);

    // Table-driven functional sequence
    for (int i = 0; i < 13; i++) begin
      time_in = tbl[i].tin;
      do_press(tbl[i].s, tbl[i].l, cn, cf, tr);
      chk($sformatf("tbl%0d_state", i), 32'(state_dbg), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_run", i),   32'(run_en), 32'(tbl[i].run));
      chk($sformatf("tbl%0d_hold", i),  32'(hold), 32'(tbl[i].hld));
      chk($sformatf("tbl%0d_tout", i),  32'(time_out), 32'(tbl[i].tout));
      chk($sformatf("tbl%0d_clr", i),   32'(cn), 32'(tbl[i].clr_n));
      chk($sformatf("tbl%0d_clrrun", i), 32'(cf), 0);
      if (i == 7) chk("simul_lap_reg", 32'(dut.lap_reg), 32'h00512);
    end

    // Bounce rejection: 3-cycle raw pulse
    @(posedge clk); #2 btn_start = 1'b1;
    repeat (3) @(posedge clk);
    #2 btn_start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("bounce_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("bounce_run",   32'(run_en), 0);

    // Start latency: run_en rises on the 8th sampling edge
    @(posedge clk); #2 btn_start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_e%0d", k), 32'(run_en), (k >= 8) ? 32'd1 : 32'd0);
    end
    #1 btn_start = 1'b0;
    repeat (15) @(posedge clk);

    // Asynchronous reset mid-RUNNING
    time_in = 20'h12345;
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("arst_run",   32'(run_en), 0);
    chk("arst_hold",  32'(hold), 0);
    chk("arst_state", 32'(state_dbg), 0);
    chk("arst_tout",  32'(time_out), 32'h12345);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (6) @(posedge clk);

    // Asynchronous reset mid-LAP discards the snapshot
    time_in = 20'h00100;
    do_press(1, 0, cn, cf, tr);
    time_in = 20'h00321;
    do_press(0, 1, cn, cf, tr);
    chk("lap_pre_tout", 32'(time_out), 32'h00321);
    time_in = 20'h00888;
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("lrst_state", 32'(state_dbg), 0);
    chk("lrst_hold",  32'(hold), 0);
    chk("lrst_lap",   32'(dut.lap_reg), 0);
    chk("lrst_tout",  32'(time_out), 32'h00888);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (6) @(posedge clk);

    // Button held across reset release
    @(posedge clk); #2 btn_start = 1'b1;
    do_reset();
    repeat (30) @(posedge clk);
    #2;
    chk("held_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("held_run",   32'(run_en), 0);
    btn_start = 1'b0;
    repeat (15) @(posedge clk);
    do_press(1, 0, cn, cf, tr);
    chk("held_repress_trans", 32'(tr), 1);
    chk("held_repress_state", 32'(state_dbg), 32'(ST_RUNNING));

    // Randomized presses against a behavioural model
    do_reset();
    m_st = 2'd0; m_lap = '0;
    for (int i = 0; i < 40; i++) begin
      int a;
      a = $urandom_range(0, 3);
      s = (a == 1) || (a == 3);
      l = (a == 2) || (a == 3);
      tin = rand_bcd();
      time_in = tin;
      do_press(s, l, cn, cf, tr);
      m_clr = 0;
      if (s) begin
        m_st = (m_st == 2'd0 || m_st == 2'd3) ? 2'd1 : 2'd3;
      end else if (l) begin
        case (m_st)
          2'd0: m_clr = 1;
          2'd1: begin m_st = 2'd2; m_lap = tin; end
          2'd2: m_st = 2'd1;
          default: begin m_st = 2'd0; m_clr = 1; end
        endcase
      end
      m_run  = (m_st == 2'd1) || (m_st == 2'd2);
      m_hold = (m_st == 2'd2);
      chk($sformatf("rnd%0d_state", i), 32'(state_dbg), 32'(m_st));
      chk($sformatf("rnd%0d_run", i),   32'(run_en), 32'(m_run));
      chk($sformatf("rnd%0d_hold", i),  32'(hold), 32'(m_hold));
      chk($sformatf("rnd%0d_tout", i),  32'(time_out), 32'(m_hold ? m_lap : tin));
      chk($sformatf("rnd%0d_clr", i),   32'(cn), 32'(m_clr));
      chk($sformatf("rnd%0d_clrrun", i), 32'(cf), 0);
      tin = rand_bcd();
      time_in = tin;
      #1;
      chk($sformatf("rnd%0d_tout_live", i), 32'(time_out), 32'(m_hold ? m_lap : tin));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
